// File: rtl/jtag_cmd_arbiter.sv
// jtag_cmd_arbiter: shares one tap_FSM between two command requesters.
// Arbitration is per transaction (a burst of commands ending in 'last'),
// round-robin on contention. The owner keeps the command and shift paths
// until its last command has executed and the TAP queue has drained.
// Optional macro JTAG_ARB_TIMEOUT_EN adds an idle-owner watchdog that
// forces a CLOSE_TEST command and releases a stalled owner.

`ifndef CMD_JTAG_CLOSE_TEST
`define CMD_JTAG_CLOSE_TEST 4'h8
`endif

module jtag_cmd_arbiter #(
  parameter int CMD_LEN     = 4,
  parameter int CYCLE_LEN   = 28,
  parameter int TIMEOUT_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_LEN-1:0]   req0_cmd,
  input  logic [CYCLE_LEN-1:0] req0_cycle_num,
  input  logic                 req0_last,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_shift_in,
  input  logic                 req0_shift_ready,
  output logic                 req0_shift_out,
  output logic                 req0_shift_valid,
  input  logic [CMD_LEN-1:0]   req1_cmd,
  input  logic [CYCLE_LEN-1:0] req1_cycle_num,
  input  logic                 req1_last,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_shift_in,
  input  logic                 req1_shift_ready,
  output logic                 req1_shift_out,
  output logic                 req1_shift_valid,
  output logic [CMD_LEN-1:0]   tap_cmd,
  output logic [CYCLE_LEN-1:0] tap_cycle_num,
  output logic                 tap_cmd_valid,
  input  logic                 tap_cmd_ready,
  input  logic                 tap_cmd_done,
  input  logic                 tap_shift,
  input  logic                 tap_shift_out,
  output logic                 tap_shift_in,
  output logic                 tap_shift_ready,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
`ifdef JTAG_ARB_TIMEOUT_EN
    ,
    ABORT = 2'd3
`endif
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic       rr_reg, rr_next;

  // Requester signals gathered into vectors so the owner can be indexed.
  logic [CMD_LEN-1:0]   req_cmd [2];
  logic [CYCLE_LEN-1:0] req_cycle_num [2];
  logic [1:0]           req_valid, req_last, req_shift_in, req_shift_ready;
  logic [1:0]           cmd_ready, shift_out_vec, shift_valid_vec;
  logic                 owner;
  logic                 accept;

  assign req_cmd[0]       = req0_cmd;
  assign req_cmd[1]       = req1_cmd;
  assign req_cycle_num[0] = req0_cycle_num;
  assign req_cycle_num[1] = req1_cycle_num;
  assign req_valid        = {req1_valid, req0_valid};
  assign req_last         = {req1_last, req0_last};
  assign req_shift_in     = {req1_shift_in, req0_shift_in};
  assign req_shift_ready  = {req1_shift_ready, req0_shift_ready};

  // grant is one-hot, so bit 1 alone identifies the owner.
  assign owner  = grant_reg[1];
  assign accept = (state_reg == GRANT) && req_valid[owner] && tap_cmd_ready;
  assign grant  = grant_reg;

`ifdef JTAG_ARB_TIMEOUT_EN
  logic [TIMEOUT_LEN-1:0] timeout_cnt_reg, timeout_cnt_next;

  // Watchdog counts owner cycles without an accept; cleared outside GRANT.
  always_comb begin
    timeout_cnt_next = '0;
    if (state_reg == GRANT && !accept)
      timeout_cnt_next = timeout_cnt_reg + {{(TIMEOUT_LEN-1){1'b0}}, 1'b1};
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) timeout_cnt_reg <= '0;
    else     timeout_cnt_reg <= timeout_cnt_next;
  end
`endif

  // Next-state, grant/round-robin update and the command path mux.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_next       = rr_reg;
    tap_cmd       = '0;
    tap_cycle_num = '0;
    tap_cmd_valid = 1'b0;
    cmd_ready     = 2'b00;
    case (state_reg)
      IDLE: begin
        // Grant only; no command is accepted in the arbitration cycle.
        if (|req_valid) begin
          state_next = GRANT;
          if (req_valid == 2'b11) grant_next = rr_reg ? 2'b10 : 2'b01;
          else                    grant_next = req_valid;
        end
      end
      GRANT: begin
        tap_cmd          = req_cmd[owner];
        tap_cycle_num    = req_cycle_num[owner];
        tap_cmd_valid    = req_valid[owner];
        cmd_ready[owner] = tap_cmd_ready;
        if (accept && req_last[owner]) state_next = DRAIN;
`ifdef JTAG_ARB_TIMEOUT_EN
        else if (!accept && timeout_cnt_reg == '1) state_next = ABORT;
`endif
      end
      DRAIN: begin
        // Queue empty: release and hand priority to the other requester.
        if (tap_cmd_done) begin
          state_next = IDLE;
          grant_next = 2'b00;
          rr_next    = ~owner;
        end
      end
`ifdef JTAG_ARB_TIMEOUT_EN
      ABORT: begin
        tap_cmd       = CMD_LEN'(`CMD_JTAG_CLOSE_TEST);
        tap_cmd_valid = 1'b1;
        if (tap_cmd_ready) state_next = DRAIN;
      end
`endif
      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
      end
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      rr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
    end
  end

  // Shift return path: only the owner sees TDO and shift activity.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign shift_out_vec[gi]   = grant_reg[gi] & tap_shift_out;
    assign shift_valid_vec[gi] = grant_reg[gi] & tap_shift;
  end

  // Shift source follows grant; with no owner the TAP sees idle data.
  always_comb begin
    tap_shift_in    = 1'b0;
    tap_shift_ready = 1'b1;
    if (|grant_reg) begin
      tap_shift_in    = req_shift_in[owner];
      tap_shift_ready = req_shift_ready[owner];
    end
  end

  assign req0_ready       = cmd_ready[0];
  assign req1_ready       = cmd_ready[1];
  assign req0_shift_out   = shift_out_vec[0];
  assign req1_shift_out   = shift_out_vec[1];
  assign req0_shift_valid = shift_valid_vec[0];
  assign req1_shift_valid = shift_valid_vec[1];

endmodule

// File: tb/tb_jtag_cmd_arbiter.sv
// Directed self-checking bench for jtag_cmd_arbiter. The tap_FSM side is
// driven directly by the stimulus. Timeout scenario runs only when
// JTAG_ARB_TIMEOUT_EN is defined.

`ifndef CMD_JTAG_CLOSE_TEST
`define CMD_JTAG_CLOSE_TEST 4'h8
`endif

module tb_jtag_cmd_arbiter;
  localparam int CMD_LEN   = 4;
  localparam int CYCLE_LEN = 28;
  localparam logic [3:0] LOAD_IR    = 4'h1;
  localparam logic [3:0] LOAD_DR    = 4'h2;
  localparam logic [3:0] IDLE_DELAY = 4'h4;
  localparam logic [3:0] CLOSE_CMD  = `CMD_JTAG_CLOSE_TEST;

  logic clk = 1'b0;
  logic rst;
  logic [CMD_LEN-1:0]   req0_cmd, req1_cmd;
  logic [CYCLE_LEN-1:0] req0_cycle_num, req1_cycle_num;
  logic req0_last, req0_valid, req0_ready, req0_shift_in, req0_shift_ready;
  logic req0_shift_out, req0_shift_valid;
  logic req1_last, req1_valid, req1_ready, req1_shift_in, req1_shift_ready;
  logic req1_shift_out, req1_shift_valid;
  logic [CMD_LEN-1:0]   tap_cmd;
  logic [CYCLE_LEN-1:0] tap_cycle_num;
  logic tap_cmd_valid, tap_cmd_ready, tap_cmd_done, tap_shift, tap_shift_out;
  logic tap_shift_in, tap_shift_ready;
  logic [1:0] grant;

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int sv0_cnt = 0;
  int sv1_cnt = 0;

  jtag_cmd_arbiter #(.CMD_LEN(CMD_LEN), .CYCLE_LEN(CYCLE_LEN), .TIMEOUT_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .req0_cmd(req0_cmd), .req0_cycle_num(req0_cycle_num), .req0_last(req0_last),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_shift_in(req0_shift_in),
    .req0_shift_ready(req0_shift_ready), .req0_shift_out(req0_shift_out),
    .req0_shift_valid(req0_shift_valid),
    .req1_cmd(req1_cmd), .req1_cycle_num(req1_cycle_num), .req1_last(req1_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_shift_in(req1_shift_in),
    .req1_shift_ready(req1_shift_ready), .req1_shift_out(req1_shift_out),
    .req1_shift_valid(req1_shift_valid),
    .tap_cmd(tap_cmd), .tap_cycle_num(tap_cycle_num), .tap_cmd_valid(tap_cmd_valid),
    .tap_cmd_ready(tap_cmd_ready), .tap_cmd_done(tap_cmd_done), .tap_shift(tap_shift),
    .tap_shift_out(tap_shift_out), .tap_shift_in(tap_shift_in),
    .tap_shift_ready(tap_shift_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  // Accepted commands on the TAP port.
  always @(posedge clk) begin
    if (rst) acc_cnt <= 0;
    else if (tap_cmd_valid && tap_cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  // Cycles each requester sees shift_valid.
  always @(negedge clk) begin
    if (req0_shift_valid) sv0_cnt <= sv0_cnt + 1;
    if (req1_shift_valid) sv1_cnt <= sv1_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_cmd = '0; req0_cycle_num = '0; req0_last = 0; req0_valid = 0;
    req0_shift_in = 0; req0_shift_ready = 0;
    req1_cmd = '0; req1_cycle_num = '0; req1_last = 0; req1_valid = 0;
    req1_shift_in = 0; req1_shift_ready = 0;
    tap_cmd_ready = 1; tap_cmd_done = 0; tap_shift = 0; tap_shift_out = 0;
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_tap_valid", tap_cmd_valid, 0);
    chk("rst_tap_cmd", tap_cmd, 0);
    chk("rst_tap_cycle", tap_cycle_num, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_shift_out", {req1_shift_out, req0_shift_out}, 0);
    chk("rst_shift_valid", {req1_shift_valid, req0_shift_valid}, 0);
    chk("rst_tap_shift_in", tap_shift_in, 0);
    chk("rst_tap_shift_ready", tap_shift_ready, 1);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    int base0, base1;
    logic found;

    // ---- single requester, three-command transaction ----
    do_reset();
    req0_cmd = LOAD_IR; req0_cycle_num = 10; req0_last = 0; req0_valid = 1; #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_no_ready", req0_ready, 0);
    step();
    $display("t1 grant=%b tap_cmd=%0h", grant, tap_cmd);
    chk("t1_grant01", grant, 2'b01);
    chk("t1_cmd0", tap_cmd, LOAD_IR);
    chk("t1_cyc0", tap_cycle_num, 10);
    chk("t1_valid0", tap_cmd_valid, 1);
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step();
    req0_cmd = LOAD_DR; req0_cycle_num = 32; #1;
    chk("t1_cmd1", tap_cmd, LOAD_DR);
    chk("t1_cyc1", tap_cycle_num, 32);
    step();
    req0_cmd = IDLE_DELAY; req0_cycle_num = 100; req0_last = 1; #1;
    chk("t1_cmd2", tap_cmd, IDLE_DELAY);
    chk("t1_cyc2", tap_cycle_num, 100);
    step();
    // DRAIN: keep valid high to prove the command port is closed
    req0_last = 0; #1;
    $display("t1 drain accepts=%0d grant=%b", acc_cnt, grant);
    chk("t1_accepts", acc_cnt, 3);
    chk("t1_drain_grant", grant, 2'b01);
    chk("t1_drain_valid", tap_cmd_valid, 0);
    chk("t1_drain_ready", req0_ready, 0);
    step();
    chk("t1_drain_hold", grant, 2'b01);
    tap_cmd_done = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("t1_release", grant, 2'b00);
    step();
    chk("t1_regrant", grant, 2'b01);
    // reset while owning
    rst = 1; step(); rst = 0;
    chk("rst_in_grant", grant, 2'b00);
    chk("rst_in_grant_valid", tap_cmd_valid, 0);

    // ---- contention and round robin ----
    do_reset();
    req0_cmd = 4'h3; req0_cycle_num = 5; req0_last = 1; req0_valid = 1;
    req1_cmd = 4'h6; req1_cycle_num = 7; req1_last = 1; req1_valid = 1;
    step();
    $display("t2 first grant=%b", grant);
    chk("t2_first_grant", grant, 2'b01);
    chk("t2_first_cmd", tap_cmd, 4'h3);
    chk("t2_first_r0", req0_ready, 1);
    chk("t2_first_r1", req1_ready, 0);
    step();
    req0_valid = 0; #1;
    chk("t2_drain_grant", grant, 2'b01);
    chk("t2_drain_r1", req1_ready, 0);
    chk("t2_drain_valid", tap_cmd_valid, 0);
    tap_cmd_done = 1;
    req0_cmd = 4'h9; req0_cycle_num = 11; req0_last = 1; req0_valid = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("t2_release", grant, 2'b00);
    step();
    $display("t2 contested grant=%b", grant);
    chk("t2_rr_grant", grant, 2'b10);
    chk("t2_rr_cmd", tap_cmd, 4'h6);
    chk("t2_rr_cyc", tap_cycle_num, 7);
    chk("t2_rr_r1", req1_ready, 1);
    chk("t2_rr_r0", req0_ready, 0);

    // ---- waiting requester stalled while owner is backpressured ----
    tap_cmd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_r0", req0_ready, 0);
      chk("t3_stall_r1", req1_ready, 0);
      chk("t3_stall_cmd", tap_cmd, 4'h6);
      step();
    end
    tap_cmd_ready = 1; #1;
    chk("t3_owner_ready", req1_ready, 1);
    step();
    req1_valid = 0; #1;
    chk("t3_drain_r0", req0_ready, 0);
    chk("t3_drain_cmdv", tap_cmd_valid, 0);
    tap_cmd_done = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("t3_release", grant, 2'b00);
    step();
    $display("t3 waiter grant=%b cmd=%0h", grant, tap_cmd);
    chk("t3_waiter_grant", grant, 2'b01);
    chk("t3_waiter_cmd", tap_cmd, 4'h9);
    chk("t3_waiter_cyc", tap_cycle_num, 11);

    // ---- last command queued for 200 cycles: grant holds ----
    req1_cmd = LOAD_DR; req1_cycle_num = 16; req1_last = 1; req1_valid = 1;
    step();
    req0_valid = 0; #1;
    for (int i = 0; i < 200; i++) begin
      chk("t5_hold_grant", grant, 2'b01);
      chk("t5_hold_r1", req1_ready, 0);
      step();
    end
    $display("t5 after 200 cycles grant=%b", grant);
    tap_cmd_done = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("t5_release", grant, 2'b00);
    step();
    chk("t5_next_grant", grant, 2'b10);
    chk("t5_next_cmd", tap_cmd, LOAD_DR);
    chk("t5_next_cyc", tap_cycle_num, 16);
    step();
    req1_valid = 0; #1;

    // ---- 16-bit shift from req1 in DRAIN, req0 drives inverted data ----
    pat = 16'hA5C3;
    base0 = sv0_cnt;
    base1 = sv1_cnt;
    for (int i = 0; i < 16; i++) begin
      tap_shift = 1;
      tap_shift_out = i[0];
      req1_shift_in = pat[i];
      req0_shift_in = ~pat[i];
      req1_shift_ready = (i != 15);
      req0_shift_ready = 1'b0;
      #1;
      chk("t4_tdi", tap_shift_in, pat[i]);
      chk("t4_shift_ready", tap_shift_ready, (i != 15));
      chk("t4_tdo1", req1_shift_out, i[0]);
      chk("t4_tdo0", req0_shift_out, 0);
      chk("t4_sv0", req0_shift_valid, 0);
      step();
    end
    tap_shift = 0; tap_shift_out = 0;
    step();
    step();
    $display("t4 shift_valid cycles req1=%0d req0=%0d", sv1_cnt - base1, sv0_cnt - base0);
    chk("t4_sv1_count", sv1_cnt - base1, 16);
    chk("t4_sv0_count", sv0_cnt - base0, 0);
    tap_cmd_done = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("t4_release", grant, 2'b00);
    chk("t4_idle_tdi", tap_shift_in, 0);
    chk("t4_idle_shift_ready", tap_shift_ready, 1);

`ifdef JTAG_ARB_TIMEOUT_EN
    // ---- silent owner is aborted with CLOSE_TEST ----
    do_reset();
    req0_cmd = LOAD_IR; req0_cycle_num = 3; req0_last = 0; req0_valid = 1;
    req1_cmd = 4'h6; req1_cycle_num = 9; req1_last = 1; req1_valid = 1;
    step();
    req0_valid = 0; #1;
    chk("to_grant", grant, 2'b01);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (tap_cmd_valid === 1'b1 && tap_cmd === CLOSE_CMD) found = 1'b1;
    end
    $display("to close_test seen=%0b", found);
    chk("to_close_seen", found, 1);
    chk("to_close_cyc", tap_cycle_num, 0);
    chk("to_close_r1", req1_ready, 0);
    step();
    chk("to_drain_valid", tap_cmd_valid, 0);
    tap_cmd_done = 1;
    step();
    tap_cmd_done = 0; #1;
    chk("to_release", grant, 2'b00);
    step();
    chk("to_next_grant", grant, 2'b10);
    chk("to_next_cmd", tap_cmd, 4'h6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_arbiter.md
# jtag_cmd_arbiter

Shares one `tap_FSM` instance between two command requesters, for example a host command bridge on port 0 and a bitstream loader on port 1. Arbitration is per transaction: a transaction is a burst of commands ending with a `last` flag. Once a requester is granted, it owns the TAP command port and the shift-data path until its last command has executed and the TAP command queue has drained. The block sits directly between the requesters and `tap_FSM`.

## Interface
- `CMD_LEN`, 4: command width; matches `tap_FSM`.
- `CYCLE_LEN`, 28: cycle count width; matches `tap_FSM`.
- `TIMEOUT_LEN`, 16: width of the idle-owner watchdog counter (used only with the macro).
- `clk  in  1  clock`
- `rst  in  1  reset: synchronous, active-high`
- `reqN_cmd  in  CMD_LEN  command from requester N (N = 0, 1)`
- `reqN_cycle_num  in  CYCLE_LEN  cycle count from requester N`
- `reqN_last  in  1  marks the final command of the transaction`
- `reqN_valid  in  1  command valid`
- `reqN_ready  out  1  command accepted when valid and ready are both high`
- `reqN_shift_in  in  1  TDI bit source`
- `reqN_shift_ready  in  1  shift FIFO not at its last bit`
- `reqN_shift_out  out  1  TDO bit`
- `reqN_shift_valid  out  1  `reqN_shift_out` is meaningful`
- `tap_cmd  out  CMD_LEN`, `tap_cycle_num  out  CYCLE_LEN`, `tap_cmd_valid  out  1`: command to `tap_FSM`
- `tap_cmd_ready  in  1`, `tap_cmd_done  in  1`, `tap_shift  in  1`, `tap_shift_out  in  1`: status from `tap_FSM`
- `tap_shift_in  out  1`, `tap_shift_ready  out  1`: shift data to `tap_FSM`
- `grant  out  2  one-hot owner; 00 = none`

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner's commands are forwarded.
  - DRAIN: owner's last command has been accepted; waiting for the queue to empty.
  - ABORT: only present with the macro.
- IDLE:
  - If one requester has `valid` high, grant it.
  - If both do, grant the one selected by the round-robin pointer `rr`. `rr` resets to 0.
  - Move to GRANT and set `grant`. No command is accepted in this cycle.
- GRANT:
  - `tap_cmd`, `tap_cycle_num` and `tap_cmd_valid` are combinational copies of the owner's `cmd`, `cycle_num` and `valid`.
  - Owner's `ready` equals `tap_cmd_ready`. Non-owner's `ready` is 0.
  - When a command is accepted with `last` set, move to DRAIN.
- DRAIN:
  - `tap_cmd_valid` is 0 and both `ready` outputs are 0.
  - When `tap_cmd_done` is 1, move to IDLE, clear `grant`, and set `rr` to the other requester.
- Shift routing follows `grant` in GRANT, DRAIN and ABORT:
  - `tap_shift_in` and `tap_shift_ready` are the owner's `shift_in` and `shift_ready`.
  - Owner's `shift_out` is `tap_shift_out` and its `shift_valid` is `tap_shift`.
  - Non-owner's `shift_out` and `shift_valid` are 0.
  - In IDLE, `tap_shift_in` is 0 and `tap_shift_ready` is 1.
- A non-owner holding `valid` high is stalled with no loss of data; `valid` must stay asserted until the command is accepted.
- `rst` while in any state: return to IDLE with `grant` = 00. `tap_FSM` shares this `rst`, so its queue also clears.

## Timing
- Reset values:
  - `grant` = 00.
  - `tap_cmd_valid`, `tap_cmd`, `tap_cycle_num`, both `reqN_ready`, both `reqN_shift_out`, both `reqN_shift_valid`, `tap_shift_in` = 0.
  - `tap_shift_ready` = 1.
- Arbitration latency: `valid` high in IDLE at cycle t, `grant` set at t+1, earliest accept at t+1.
- Release: `tap_cmd_done` high in DRAIN at cycle t, `grant` = 00 at t+1, new grant at t+2 at the earliest.
- Back-to-back transactions from the same requester with no contention still pass through IDLE, costing 1 idle cycle.
- DRAIN never sees a stale `tap_cmd_done`. The queue write pointer increments on the accept edge, so `tap_cmd_done` is 0 on the first DRAIN cycle.

## Configuration
- `JTAG_ARB_TIMEOUT_EN` defined:
  - In GRANT, a counter increments on every cycle with no accept and clears on every accept.
  - When it reaches all-ones, the state moves to ABORT.
  - ABORT drives `tap_cmd` = `` `CMD_JTAG_CLOSE_TEST `` with `tap_cycle_num` = 0 and `tap_cmd_valid` = 1 until that command is accepted, then moves to DRAIN.
  - On completion the owner is released and `rr` toggles as normal.
- Not defined: no counter, no ABORT state, and an owner may hold the grant indefinitely.

## Test plan
- Reset, then req0 sends 3 commands (LOAD_IR with cycle 10; LOAD_DR with cycle 32; IDLE_DELAY with cycle 100, `last` set).
  - `grant` = 01 one cycle after `valid`.
  - 3 accepts seen on the tap port.
  - `grant` = 00 one cycle after `tap_cmd_done`.
- req0 and req1 both assert `valid` in the same cycle after reset:
  - req0 is granted first, then req1 is granted immediately after req0 releases.
  - When both assert again, req1 wins its next contested round.
- req1 asserts `valid` while req0 is in GRANT:
  - `req1_ready` stays 0.
  - req1's commands appear on `tap_cmd` only after req0's DRAIN completes.
- LOAD_DR with 16 bits from req1 while req0 drives inverted shift data:
  - `tap_shift_in` matches req1's stream.
  - `req1_shift_valid` is high for exactly 16 cycles.
  - `req0_shift_valid` stays 0.
- Owner's last command is still queued (`tap_cmd_done` = 0 for 200 cycles): `grant` holds and no other requester is accepted.
- With `JTAG_ARB_TIMEOUT_EN` and `TIMEOUT_LEN` = 4: req0 is granted, then sends nothing for 15 cycles.
  - CLOSE_TEST is issued on `tap_cmd`.
  - req0 is released and req1 is granted next.
